// File: rtl/rtx_pkg.sv
// Shared ray-tracer types: fixed-point scalars, colours, materials, and the
// material-dictionary load packet layout.
package rtx_pkg;

  // Q8.16 fixed point carried as a raw 24-bit word
  localparam int unsigned FP_BITS = 24;
  localparam int unsigned FP_FRAC = 16;
  localparam logic [FP_BITS-1:0] FP_ONE = FP_BITS'(1) << FP_FRAC;

  typedef logic [FP_BITS-1:0] fp;

  typedef struct packed {
    fp x;
    fp y;
    fp z;
  } fp_color;

  typedef struct packed {
    fp_color    color;
    fp_color    spec_color;
    fp_color    emit_color;
    fp          smoothness;
    logic [7:0] specular_prob;
  } material;

  // Field words following the header word of a load packet
  localparam int unsigned MAT_WORDS        = 11;
  localparam int unsigned MAT_HDR_IDX_BITS = 8;
  localparam int unsigned MAT_FP_FIELDS    = MAT_WORDS - 1;
  localparam int unsigned MAT_CNT_BITS     = 4;

  typedef enum logic [1:0] {
    DS_IDLE    = 2'd0,
    DS_COLLECT = 2'd1,
    DS_COMMIT  = 2'd2
  } deser_state_e;

endpackage

// File: rtl/material_deserializer.sv
// Assembles 12-word load packets into a staged material and issues a single
// commit strobe per complete packet; flags aborted or out-of-range packets.
module material_deserializer
  import rtx_pkg::*;
#(
  parameter int unsigned NUM_MATS = 16,
  parameter int unsigned IDX_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FP_BITS-1:0] load_data,
  input  logic               load_first,
  input  logic               load_valid,
  output logic               load_ready,
  output logic               wr_en,
  output logic [IDX_W-1:0]   wr_idx,
  output material            wr_mat,
  output logic               err
);

  localparam logic [MAT_CNT_BITS-1:0] LAST_CNT = MAT_CNT_BITS'(MAT_WORDS - 1);
  localparam logic [MAT_CNT_BITS-1:0] PROB_CNT = MAT_CNT_BITS'(MAT_FP_FIELDS);

  deser_state_e                state_q, state_d;
  logic [MAT_CNT_BITS-1:0]     cnt_q, cnt_d;
  logic [MAT_HDR_IDX_BITS-1:0] hdr_q, hdr_d;
  logic [FP_BITS-1:0]          fields_q [MAT_FP_FIELDS];
  logic [7:0]                  prob_q;
  logic                        ready_q;
  logic                        wr_en_q;
  logic                        err_q;

  logic accept_c;
  logic field_we_c;
  logic abort_c;
  logic hdr_in_range_c;

  assign accept_c       = load_valid & ready_q;
  assign hdr_in_range_c = 32'(hdr_q) < NUM_MATS;

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hdr_d      = hdr_q;
    field_we_c = 1'b0;
    abort_c    = 1'b0;
    case (state_q)
      DS_IDLE: begin
        if (accept_c && load_first) begin
          state_d = DS_COLLECT;
          cnt_d   = '0;
          hdr_d   = load_data[MAT_HDR_IDX_BITS-1:0];
        end
      end
      DS_COLLECT: begin
        if (accept_c) begin
          if (load_first) begin
            // A fresh header abandons the partial packet and restarts collection
            abort_c = 1'b1;
            cnt_d   = '0;
            hdr_d   = load_data[MAT_HDR_IDX_BITS-1:0];
          end else begin
            field_we_c = 1'b1;
            if (cnt_q == LAST_CNT) begin
              state_d = DS_COMMIT;
            end else begin
              cnt_d = cnt_q + MAT_CNT_BITS'(1);
            end
          end
        end
      end
      DS_COMMIT: begin
        state_d = DS_IDLE;
      end
      default: begin
        state_d = DS_IDLE;
      end
    endcase
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DS_IDLE;
      cnt_q   <= '0;
      hdr_q   <= '0;
      ready_q <= 1'b0;
      wr_en_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      ready_q <= (state_d != DS_COMMIT);
      wr_en_q <= (state_d == DS_COMMIT) && hdr_in_range_c;
      err_q   <= abort_c || ((state_d == DS_COMMIT) && !hdr_in_range_c);
    end
  end

  // Staging storage; the table only sees it on a commit strobe
  always_ff @(posedge clk) begin
    if (field_we_c) begin
      if (cnt_q == PROB_CNT) begin
        prob_q <= load_data[7:0];
      end else if (cnt_q < PROB_CNT) begin
        fields_q[cnt_q] <= load_data;
      end
    end
  end

  assign load_ready = ready_q;
  assign wr_en      = wr_en_q;
  assign wr_idx     = hdr_q[IDX_W-1:0];
  assign err        = err_q;
  assign wr_mat     = {fields_q[0], fields_q[1], fields_q[2],
                       fields_q[3], fields_q[4], fields_q[5],
                       fields_q[6], fields_q[7], fields_q[8],
                       fields_q[9], prob_q};

endmodule

// File: rtl/material_dict.sv
// Material dictionary responder: runtime-loaded material table with a fixed
// 2-cycle read pipeline, entry-valid tracking and load status.
module material_dict
  import rtx_pkg::*;
#(
  parameter int unsigned NUM_MATS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         rd_idx,
  output material            rd_mat,
  input  logic [FP_BITS-1:0] load_data,
  input  logic               load_first,
  input  logic               load_valid,
  output logic               load_ready,
  output logic               load_err,
  output logic [8:0]         mats_loaded
);

  localparam int unsigned IDX_W     = $clog2(NUM_MATS);
  localparam int unsigned NUM_SLOTS = 1 << IDX_W;

  logic                 wr_en;
  logic [IDX_W-1:0]     wr_idx;
  material              wr_mat;
  logic                 deser_err;

  material              tbl [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] valid_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 in_range_q;

  material_deserializer #(
    .NUM_MATS (NUM_MATS),
    .IDX_W    (IDX_W)
  ) u_deser (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_data  (load_data),
    .load_first (load_first),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_mat     (wr_mat),
    .err        (deser_err)
  );

  // Table storage is deliberately unreset; valid_q gates every read
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tbl[wr_idx] <= wr_mat;
    end
  end

  // Valid bitmap, distinct-entry counter and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      mats_loaded <= '0;
      load_err    <= 1'b0;
    end else begin
      if (wr_en) begin
        valid_q[wr_idx] <= 1'b1;
        if (!valid_q[wr_idx]) begin
          mats_loaded <= mats_loaded + 9'd1;
        end
      end
      if (deser_err) begin
        load_err <= 1'b1;
      end
    end
  end

  // Read pipe; stage 2 samples table and bitmap before a same-edge commit lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      in_range_q <= 1'b0;
      rd_mat     <= '0;
    end else begin
      idx_q      <= rd_idx[IDX_W-1:0];
      in_range_q <= 32'(rd_idx) < NUM_MATS;
      rd_mat     <= (in_range_q && valid_q[idx_q]) ? tbl[idx_q] : '0;
    end
  end

endmodule

// File: tb/tb_material_dict.sv
// Directed self-checking bench for material_dict.
module tb_material_dict;
  import rtx_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [7:0]         rd_idx;
  material            rd_mat;
  logic [FP_BITS-1:0] load_data;
  logic               load_first;
  logic               load_valid;
  logic               load_ready;
  logic               load_err;
  logic [8:0]         mats_loaded;

  int checks   = 0;
  int failures = 0;

  material mzero, m3, m3b, m6, m8, mbad;

  always #5 clk = ~clk;

  material_dict #(.NUM_MATS(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_idx      (rd_idx),
    .rd_mat      (rd_mat),
    .load_data   (load_data),
    .load_first  (load_first),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_err    (load_err),
    .mats_loaded (mats_loaded)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FP_BITS-1:0] mat_word(input material m, input int k);
    case (k)
      1:  return m.color.x;
      2:  return m.color.y;
      3:  return m.color.z;
      4:  return m.spec_color.x;
      5:  return m.spec_color.y;
      6:  return m.spec_color.z;
      7:  return m.emit_color.x;
      8:  return m.emit_color.y;
      9:  return m.emit_color.z;
      10: return m.smoothness;
      default: return {16'hABCD, m.specular_prob};
    endcase
  endfunction

  task automatic send_word(input logic [FP_BITS-1:0] d, input logic f);
    int n = 0;
    load_data  = d;
    load_first = f;
    load_valid = 1'b1;
    while (!load_ready && n < 32) begin
      step();
      n++;
    end
    if (!load_ready) check("load_ready_wait", 256'(load_ready), 256'(1));
    step();
  endtask

  // Returns in the commit cycle with load_valid low
  task automatic send_packet(input logic [7:0] idx, input material m);
    send_word({16'h0, idx}, 1'b1);
    for (int k = 1; k <= 11; k++) send_word(mat_word(m, k), 1'b0);
    load_valid = 1'b0;
    load_first = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [7:0] idx, input material exp);
    rd_idx = idx;
    step();
    step();
    check(tag, 256'(rd_mat), 256'(exp));
  endtask

  task automatic do_reset();
    load_valid = 1'b0;
    load_first = 1'b0;
    rst_n      = 1'b0;
    #12;
    check("rst_rd_mat", 256'(rd_mat), 256'(0));
    check("rst_load_ready", 256'(load_ready), 256'(0));
    check("rst_load_err", 256'(load_err), 256'(0));
    check("rst_mats_loaded", 256'(mats_loaded), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst_ready_rise", 256'(load_ready), 256'(1));
  endtask

  initial begin
    rst_n      = 1'b0;
    rd_idx     = 8'd0;
    load_data  = '0;
    load_first = 1'b0;
    load_valid = 1'b0;

    mzero = '0;
    m3 = mzero;
    m3.color.x = FP_ONE; m3.color.y = FP_ONE; m3.color.z = FP_ONE;
    m3.smoothness = FP_ONE;
    m3.specular_prob = 8'd128;
    m3b = m3;
    m3b.emit_color.x = FP_ONE; m3b.emit_color.y = FP_ONE; m3b.emit_color.z = FP_ONE;
    m6 = mzero;
    m6.color.x = 24'h000100; m6.color.y = 24'h000200; m6.color.z = 24'h000300;
    m6.spec_color.z = 24'h111111;
    m6.emit_color.x = 24'h000123;
    m6.smoothness = 24'h008000;
    m6.specular_prob = 8'd7;
    m8 = mzero;
    m8.color.x = 24'h123456;
    m8.spec_color.y = 24'h00FF00;
    m8.smoothness = 24'h000001;
    m8.specular_prob = 8'hFF;
    mbad = '1;

    // Reset state and empty-table reads
    do_reset();
    rd_idx = 8'd3;
    step();
    step();
    check("t1_rd_cycle2", 256'(rd_mat), 256'(0));
    step();
    check("t1_rd_cycle3", 256'(rd_mat), 256'(0));

    // Single load and read-back
    send_packet(8'd3, m3);
    step();
    check("t2_mats_loaded", 256'(mats_loaded), 256'(1));
    check("t2_load_err", 256'(load_err), 256'(0));
    read_check("t2_rd3", 8'd3, m3);
    read_check("t2_rd4", 8'd4, mzero);

    // Back-to-back reads 3,4,3,15
    rd_idx = 8'd3;  step();
    rd_idx = 8'd4;  step();
    check("t3_rd_a", 256'(rd_mat), 256'(m3));
    rd_idx = 8'd3;  step();
    check("t3_rd_b", 256'(rd_mat), 256'(mzero));
    rd_idx = 8'd15; step();
    check("t3_rd_c", 256'(rd_mat), 256'(m3));
    step();
    check("t3_rd_d", 256'(rd_mat), 256'(mzero));

    // Aborted packet followed by a full one
    do_reset();
    send_word(24'h000005, 1'b1);
    for (int k = 1; k <= 4; k++) send_word(mat_word(m8, k), 1'b0);
    send_packet(8'd6, m6);
    step();
    check("t4_load_err", 256'(load_err), 256'(1));
    check("t4_mats_loaded", 256'(mats_loaded), 256'(1));
    read_check("t4_rd5", 8'd5, mzero);
    read_check("t4_rd6", 8'd6, m6);

    // Out-of-range index whose low bits alias entry 8
    do_reset();
    send_packet(8'd8, m8);
    step();
    check("t5_err_before", 256'(load_err), 256'(0));
    send_packet(8'd200, mbad);
    step();
    check("t5_load_err", 256'(load_err), 256'(1));
    check("t5_mats_loaded", 256'(mats_loaded), 256'(1));
    read_check("t5_rd8", 8'd8, m8);
    read_check("t5_rd200", 8'd200, mzero);

    // Reload during held reads: read-first on the commit cycle
    do_reset();
    send_packet(8'd3, m3);
    step();
    read_check("t6_rd3_initial", 8'd3, m3);
    send_packet(8'd3, m3b);
    check("t6_commit_ready", 256'(load_ready), 256'(0));
    step();
    check("t6_rd_old", 256'(rd_mat), 256'(m3));
    step();
    check("t6_rd_new", 256'(rd_mat), 256'(m3b));
    check("t6_mats_loaded", 256'(mats_loaded), 256'(1));

    // Reset in the middle of a packet
    send_word(24'h000003, 1'b1);
    for (int k = 1; k <= 3; k++) send_word(mat_word(m6, k), 1'b0);
    load_valid = 1'b0;
    do_reset();
    read_check("t6_rst_rd3", 8'd3, mzero);
    check("t6_rst_mats", 256'(mats_loaded), 256'(0));
    send_packet(8'd2, m6);
    step();
    read_check("t6_post_rst_rd2", 8'd2, m6);
    check("t6_post_rst_err", 256'(load_err), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
